// File: rtl/hazard_pkg.sv
// Shared constants and width helpers for the hazard scoreboard.
package hazard_pkg;

    localparam int unsigned DEF_NUM_REGS = 32;
    localparam int unsigned DEF_MAX_LAT  = 8;

    // Register-index width; at least one bit.
    function automatic int unsigned calc_aw(input int unsigned num_regs);
        return (num_regs < 2) ? 1 : $clog2(num_regs);
    endfunction

    // Countdown width able to hold 0..max_lat.
    function automatic int unsigned calc_lw(input int unsigned max_lat);
        return $clog2(max_lat + 1);
    endfunction

    // Population-count width able to hold 0..num_regs.
    function automatic int unsigned calc_pcw(input int unsigned num_regs);
        return $clog2(num_regs + 1);
    endfunction

endpackage

// File: rtl/scoreboard_entry.sv
// One register's pending flag and result countdown.
module scoreboard_entry #(
    parameter int unsigned LW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          set,
    input  logic [LW-1:0] set_lat,
    input  logic          clr,
    output logic          pending,
    output logic [LW-1:0] cnt,
    output logic          pending_nxt_c
);

    logic          pending_d, pending_q;
    logic [LW-1:0] cnt_d, cnt_q;

    // Next state: flush beats issue, issue beats writeback, otherwise count down.
    always_comb begin
        pending_d = pending_q;
        cnt_d     = cnt_q;
        if (flush) begin
            pending_d = 1'b0;
            cnt_d     = '0;
        end else if (set) begin
            pending_d = 1'b1;
            cnt_d     = set_lat;
        end else if (clr) begin
            pending_d = 1'b0;
            cnt_d     = '0;
        end else if (pending_q && (cnt_q != '0)) begin
            cnt_d = cnt_q - LW'(1);
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pending_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    assign pending       = pending_q;
    assign cnt           = cnt_q;
    assign pending_nxt_c = pending_d;

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage RAW/WAW hazard scoreboard with optional forwarding of completed results.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter  int unsigned NUM_REGS = DEF_NUM_REGS,
    parameter  int unsigned MAX_LAT  = DEF_MAX_LAT,
    parameter  int unsigned FWD_EN   = 1,
    localparam int unsigned AW       = calc_aw(NUM_REGS),
    localparam int unsigned LW       = calc_lw(MAX_LAT),
    localparam int unsigned PCW      = calc_pcw(NUM_REGS)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           id_valid,
    input  logic           id_single_src,
    input  logic [AW-1:0]  id_src1,
    input  logic [AW-1:0]  id_src2,
    input  logic           id_wb_en,
    input  logic [AW-1:0]  id_dest,
    input  logic [LW-1:0]  id_latency,
    input  logic           wb_valid,
    input  logic [AW-1:0]  wb_dest,
    output logic           hazard_detected,
    output logic           fwd_hit1,
    output logic           fwd_hit2,
    output logic [PCW-1:0] pending_cnt
);

    localparam logic FWD = (FWD_EN != 0);

    logic [NUM_REGS-1:0] pend_vec;
    logic [NUM_REGS-1:0] pend_nxt;
    logic [LW-1:0]       cnt_arr [NUM_REGS];
    logic [LW-1:0]       lat_clamped;
    logic                raw1, raw2, waw, issue_wr;
    logic [PCW-1:0]      pending_cnt_d, pending_cnt_q;

    // Register 0 is hard-wired idle.
    assign pend_vec[0] = 1'b0;
    assign pend_nxt[0] = 1'b0;
    assign cnt_arr[0]  = '0;

    // Latencies beyond the supported maximum are clamped.
    assign lat_clamped = (id_latency > LW'(MAX_LAT)) ? LW'(MAX_LAT) : id_latency;

    // Hazard and forwarding decode from current scoreboard state.
    always_comb begin
        raw1     = (id_src1 != '0) && pend_vec[id_src1] &&
                   ((cnt_arr[id_src1] != '0) || !FWD);
        raw2     = !id_single_src && (id_src2 != '0) && pend_vec[id_src2] &&
                   ((cnt_arr[id_src2] != '0) || !FWD);
        waw      = id_wb_en && (id_dest != '0) && pend_vec[id_dest];
        fwd_hit1 = id_valid && FWD && (id_src1 != '0) && pend_vec[id_src1] &&
                   (cnt_arr[id_src1] == '0);
        fwd_hit2 = id_valid && FWD && !id_single_src && (id_src2 != '0) &&
                   pend_vec[id_src2] && (cnt_arr[id_src2] == '0);
        hazard_detected = id_valid && (raw1 || raw2 || waw);
        issue_wr = id_valid && !hazard_detected && id_wb_en && (id_dest != '0);
    end

    // Per-register entries 1..NUM_REGS-1.
    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        logic set_r, clr_r;
        assign set_r = issue_wr && (id_dest == AW'(r));
        assign clr_r = wb_valid && (wb_dest == AW'(r));

        scoreboard_entry #(.LW(LW)) u_entry (
            .clk           (clk),
            .rst           (rst),
            .flush         (flush),
            .set           (set_r),
            .set_lat       (lat_clamped),
            .clr           (clr_r),
            .pending       (pend_vec[r]),
            .cnt           (cnt_arr[r]),
            .pending_nxt_c (pend_nxt[r])
        );
    end

    // Population count of the next pending vector, so the register tracks pending[].
    always_comb begin
        pending_cnt_d = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            pending_cnt_d = pending_cnt_d + PCW'(pend_nxt[r]);
        end
    end

    // Pending-count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pending_cnt_q <= '0;
        end else begin
            pending_cnt_q <= pending_cnt_d;
        end
    end

    assign pending_cnt = pending_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: one DUT with forwarding, one without, sharing stimulus.
module tb_hazard_scoreboard;

    localparam logic [3:0] MH  = 4'b0001;
    localparam logic [3:0] MF1 = 4'b0010;
    localparam logic [3:0] MF2 = 4'b0100;
    localparam logic [3:0] MP  = 4'b1000;

    logic       clk = 1'b0;
    logic       rst_n, flush, idv, iss, wbe, wbv;
    logic [4:0] s1, s2, dst, wbd;
    logic [3:0] lat;
    logic       haz_a, f1_a, f2_a, haz_b, f1_b, f2_b;
    logic [5:0] pc_a, pc_b;

    typedef struct {
        string      nm;
        int         dut;
        logic [3:0] m;
        bit         h, f1, f2;
        int         pc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.NUM_REGS(32), .MAX_LAT(8), .FWD_EN(1)) u_fwd (
        .clk(clk), .rst(rst_n), .flush(flush), .id_valid(idv), .id_single_src(iss),
        .id_src1(s1), .id_src2(s2), .id_wb_en(wbe), .id_dest(dst), .id_latency(lat),
        .wb_valid(wbv), .wb_dest(wbd), .hazard_detected(haz_a), .fwd_hit1(f1_a),
        .fwd_hit2(f2_a), .pending_cnt(pc_a)
    );

    hazard_scoreboard #(.NUM_REGS(32), .MAX_LAT(8), .FWD_EN(0)) u_nofwd (
        .clk(clk), .rst(rst_n), .flush(flush), .id_valid(idv), .id_single_src(iss),
        .id_src1(s1), .id_src2(s2), .id_wb_en(wbe), .id_dest(dst), .id_latency(lat),
        .wb_valid(wbv), .wb_dest(wbd), .hazard_detected(haz_b), .fwd_hit1(f1_b),
        .fwd_hit2(f2_b), .pending_cnt(pc_b)
    );

    task automatic cmp(input string nm, input string fld, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s.%s: got %0d want %0d", nm, fld, got, want);
        end
    endtask

    // Monitor: pops every expectation queued for this cycle and compares.
    always @(negedge clk) begin
        while (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            if (e.m[0]) cmp(e.nm, "hazard", int'(e.dut != 0 ? haz_b : haz_a), int'(e.h));
            if (e.m[1]) cmp(e.nm, "fwd1",   int'(e.dut != 0 ? f1_b : f1_a), int'(e.f1));
            if (e.m[2]) cmp(e.nm, "fwd2",   int'(e.dut != 0 ? f2_b : f2_a), int'(e.f2));
            if (e.m[3]) cmp(e.nm, "pcnt",   int'(e.dut != 0 ? pc_b : pc_a), e.pc);
        end
    end

    task automatic ex(input string nm, input int dut, input logic [3:0] m,
                      input bit h, input bit f1, input bit f2, input int pc);
        exp_t e;
        e.nm = nm; e.dut = dut; e.m = m; e.h = h; e.f1 = f1; e.f2 = f2; e.pc = pc;
        q.push_back(e);
    endtask

    // Apply one cycle of inputs just after the rising edge.
    task automatic drv(input bit v, input bit ss, input int a1, input int a2, input bit we,
                       input int d, input int l, input bit wv, input int wd,
                       input bit fl, input bit rn);
        @(posedge clk);
        #1;
        idv = v; iss = ss; s1 = 5'(a1); s2 = 5'(a2); wbe = we; dst = 5'(d);
        lat = 4'(l); wbv = wv; wbd = 5'(wd); flush = fl; rst_n = rn;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; idv = 1'b0; iss = 1'b1; wbe = 1'b0; wbv = 1'b0;
        s1 = '0; s2 = '0; dst = '0; wbd = '0; lat = '0;

        // Reset
        drv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        ex("rst_hold", 0, MH | MP, 0, 0, 0, 0);
        drv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        ex("post_rst", 0, MH | MF1 | MF2 | MP, 0, 0, 0, 0);
        ex("post_rst", 1, MH | MF1 | MF2 | MP, 0, 0, 0, 0);

        // Issue r5 latency 3, then read it
        drv(1, 1, 0, 0, 1, 5, 3, 0, 0, 0, 1);
        ex("iss5", 0, MH | MP, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            drv(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 1);
            ex("raw5_wait", 0, MH | MF1 | MP, 1, 0, 0, 1);
            ex("raw5_wait", 1, MH, 1, 0, 0, 0);
        end
        drv(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 1);
        ex("raw5_fwd", 0, MH | MF1, 0, 1, 0, 0);
        ex("raw5_nofwd", 1, MH | MF1, 1, 0, 0, 0);
        drv(0, 1, 0, 0, 0, 0, 0, 1, 5, 0, 1);
        ex("wb5_pend", 0, MP, 0, 0, 0, 1);
        ex("wb5_pend", 1, MP, 0, 0, 0, 1);
        drv(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 1);
        ex("after_wb5", 0, MH | MF1 | MP, 0, 0, 0, 0);
        ex("after_wb5", 1, MH | MP, 0, 0, 0, 0);

        // Single-source masking of src2
        drv(1, 1, 0, 0, 1, 5, 2, 0, 0, 0, 1);
        ex("iss5b", 0, MH, 0, 0, 0, 0);
        drv(1, 1, 0, 5, 0, 0, 0, 0, 0, 0, 1);
        ex("single_src", 0, MH | MF2, 0, 0, 0, 0);
        ex("single_src", 1, MH, 0, 0, 0, 0);
        drv(1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 1);
        ex("dual_src", 0, MH, 1, 0, 0, 0);
        ex("dual_src", 1, MH, 1, 0, 0, 0);
        drv(1, 0, 0, 5, 0, 0, 0, 1, 5, 0, 1);
        ex("src2_fwd", 0, MH | MF2 | MP, 0, 0, 1, 1);
        ex("src2_nofwd", 1, MH | MF2, 1, 0, 0, 0);

        // WAW
        drv(1, 1, 0, 0, 1, 7, 1, 0, 0, 0, 1);
        ex("iss7", 0, MH | MP, 0, 0, 0, 0);
        drv(1, 1, 0, 0, 1, 7, 1, 0, 0, 0, 1);
        ex("waw7", 0, MH | MP, 1, 0, 0, 1);
        ex("waw7", 1, MH, 1, 0, 0, 0);
        drv(1, 1, 0, 0, 0, 7, 1, 0, 0, 0, 1);
        ex("nowb7", 0, MH, 0, 0, 0, 0);
        ex("nowb7", 1, MH, 0, 0, 0, 0);
        drv(0, 1, 0, 0, 0, 0, 0, 1, 7, 0, 1);

        // Register 0 never pends
        drv(1, 1, 0, 0, 1, 0, 4, 0, 0, 0, 1);
        ex("iss0", 0, MH | MP, 0, 0, 0, 0);
        drv(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        ex("src0", 0, MH | MF1 | MP, 0, 0, 0, 0);
        ex("src0", 1, MH | MP, 0, 0, 0, 0);

        // Latency 15 clamps to 8
        drv(1, 1, 0, 0, 1, 3, 15, 0, 0, 0, 1);
        ex("iss3", 0, MH, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            drv(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1);
            ex("clamp_wait", 0, MH, 1, 0, 0, 0);
        end
        drv(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1);
        ex("clamp_done", 0, MH | MF1, 0, 1, 0, 0);
        ex("clamp_done", 1, MH, 1, 0, 0, 0);
        drv(0, 1, 0, 0, 0, 0, 0, 1, 3, 0, 1);

        // Issue and writeback to the same idle register: issue wins
        drv(1, 1, 0, 0, 1, 9, 2, 1, 9, 0, 1);
        ex("iss_wb9", 0, MH | MP, 0, 0, 0, 0);
        drv(1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 1);
        ex("issue_wins", 0, MH | MP, 1, 0, 0, 1);
        ex("issue_wins", 1, MH | MP, 1, 0, 0, 1);

        // Flush overrides same-cycle issue and writeback
        drv(1, 1, 0, 0, 1, 10, 5, 0, 0, 0, 1);
        ex("iss10", 0, MH, 0, 0, 0, 0);
        drv(1, 1, 0, 0, 1, 11, 5, 0, 0, 0, 1);
        ex("iss11", 0, MH, 0, 0, 0, 0);
        drv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        ex("three_pend", 0, MP, 0, 0, 0, 3);
        ex("three_pend", 1, MP, 0, 0, 0, 3);
        drv(1, 1, 0, 0, 1, 12, 3, 1, 10, 1, 1);
        ex("flush_cyc", 0, MH | MP, 0, 0, 0, 3);
        drv(1, 0, 11, 12, 0, 0, 0, 0, 0, 0, 1);
        ex("after_flush", 0, MH | MF1 | MF2 | MP, 0, 0, 0, 0);
        ex("after_flush", 1, MH | MP, 0, 0, 0, 0);

        // Reset mid-countdown
        drv(1, 1, 0, 0, 1, 10, 5, 0, 0, 0, 1);
        drv(1, 1, 0, 0, 1, 11, 5, 0, 0, 0, 1);
        drv(1, 1, 0, 0, 1, 12, 5, 0, 0, 0, 1);
        drv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        ex("three_pend2", 0, MP, 0, 0, 0, 3);
        drv(1, 1, 0, 0, 1, 13, 3, 1, 10, 1, 0);
        ex("rst_cyc", 0, MP, 0, 0, 0, 3);
        drv(1, 0, 10, 12, 0, 0, 0, 0, 0, 0, 1);
        ex("after_rst", 0, MH | MF1 | MF2 | MP, 0, 0, 0, 0);
        ex("after_rst", 1, MH | MP, 0, 0, 0, 0);

        @(posedge clk);
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, architectural register count (power of two, >=2).
REQ-002 SHALL have parameter MAX_LAT, default 8, maximum result latency in cycles (>=1).
REQ-003 SHALL have parameter FWD_EN, default 1, where 1 means a result whose countdown has reached zero is forwardable and does not stall.
REQ-004 SHALL define derived widths AW = clog2(NUM_REGS) and LW = clog2(MAX_LAT+1).
REQ-005 Ports SHALL be: clk  input  1  clock, rising edge; one clock, reset is synchronous and active-low.
REQ-006 rst  input  1  synchronous active-low reset.
REQ-007 flush  input  1  clears all pending entries.
REQ-008 id_valid  input  1  decode stage presents an instruction.
REQ-009 id_single_src  input  1  instruction reads src1 only.
REQ-010 id_src1, id_src2  input  AW each  source register numbers.
REQ-011 id_wb_en  input  1  instruction writes id_dest.
REQ-012 id_dest  input  AW  destination register number.
REQ-013 id_latency  input  LW  cycles until the result becomes forwardable (0..MAX_LAT).
REQ-014 wb_valid  input  1  writeback retires a result this cycle.
REQ-015 wb_dest  input  AW  register retired.
REQ-016 hazard_detected  output  1  stall decode; combinational from state and id_* inputs.
REQ-017 fwd_hit1, fwd_hit2  output  1 each  source satisfied by forwarding.
REQ-018 pending_cnt  output  clog2(NUM_REGS+1)  registered count of pending registers.

Function
REQ-019 Each register r SHALL hold pending[r] (1 bit) and cnt[r] (LW bits); register 0 SHALL never become pending.
REQ-020 Issue SHALL fire when id_valid=1 and hazard_detected=0.
REQ-021 On issue with id_wb_en=1 and id_dest!=0, next cycle pending[id_dest]=1 and cnt[id_dest]=id_latency.
REQ-022 Every cycle, each entry with pending=1 and cnt>0 SHALL decrement cnt by 1; cnt SHALL saturate at 0.
REQ-023 Source k (src1 always; src2 only when id_single_src=0) SHALL raise RAW if src!=0, pending[src]=1, and (cnt[src]!=0 or FWD_EN=0).
REQ-024 fwd_hitk SHALL be 1 when id_valid=1, the source is used, src!=0, pending[src]=1, cnt[src]=0, FWD_EN=1, else 0.
REQ-025 WAW SHALL be raised when id_valid=1, id_wb_en=1, id_dest!=0, and pending[id_dest]=1.
REQ-026 hazard_detected SHALL equal id_valid AND (RAW1 OR RAW2 OR WAW); it SHALL be 0 when id_valid=0.
REQ-027 wb_valid=1 SHALL clear pending[wb_dest] and cnt[wb_dest] next cycle; writeback to a non-pending register or to register 0 SHALL be ignored.
REQ-028 Simultaneous writeback and issue to the same register SHALL leave that register pending with the new cnt (issue wins).
REQ-029 id_latency > MAX_LAT SHALL be clamped to MAX_LAT.
REQ-030 flush=1 SHALL clear all entries next cycle, overriding issue and writeback in the same cycle.
REQ-031 pending_cnt SHALL equal the population count of pending[] as registered in the same cycle.

Reset
REQ-032 rst=0 at a clock edge SHALL clear all pending, cnt, and pending_cnt to 0, overriding flush, issue, and writeback.
REQ-033 During reset, combinational outputs SHALL reflect the cleared state: hazard_detected=0 and fwd_hit*=0 from the next cycle.

Structure
REQ-034 Shared package hazard_pkg SHALL hold the AW/LW derivation functions and the default NUM_REGS and MAX_LAT constants.
REQ-035 The per-register pending/countdown logic SHALL be a sub-module scoreboard_entry, instantiated NUM_REGS-1 times via generate.

Verification
REQ-036 Issue dest=5, latency=3; next cycle src1=5 -> hazard=1 for 3 cycles, then hazard=0 and fwd_hit1=1 (FWD_EN=1).
REQ-037 Same stimulus with FWD_EN=0 -> hazard stays 1 until wb_valid for register 5, then 0 on the following cycle.
REQ-038 id_single_src=1, src2=5 pending -> hazard=0; id_single_src=0 -> hazard=1.
REQ-039 dest=7 pending, new issue with dest=7 and wb_en=1 -> hazard=1 (WAW); same instruction with wb_en=0 -> hazard=0.
REQ-040 Issue dest=0 with latency=4, then src1=0 -> hazard=0 and pending_cnt stays 0.
REQ-041 Three registers pending (pending_cnt=3), then flush=1 together with issue and wb -> all clear next cycle and pending_cnt=0; rst=0 mid-countdown gives the same result.
